// File: rtl/fanout_dispatch_rr.sv
// fanout_dispatch_rr: buffers one valid/ready input stream in a small FIFO and
// deals the words out to NUM_OUT child channels in strict round-robin order.
// Optional feature macro: FANOUT_SKIP_EN -- when defined, a target that stalls
// for STALL_LIMIT cycles is skipped and the head word is re-offered to the next
// channel; when undefined, no stall counter exists and skip_pulse is tied 0.
module fanout_dispatch_rr #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_OUT     = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic [$clog2(NUM_OUT)-1:0]      tgt_ptr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            skip_pulse
);

  localparam int unsigned PTR_W = $clog2(NUM_OUT);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  // Elaboration-time guard on the legal parameter ranges
  if (NUM_OUT < 2 || NUM_OUT > 16 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STALL_LIMIT < 1) begin : g_param_check
    $error("fanout_dispatch_rr: illegal parameter combination");
  end

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_nxt;
  logic [AW-1:0]      wr_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   tgt_nxt;
  logic               ready_nxt;
  logic [NUM_OUT-1:0] valid_nxt;
  logic [DATA_W-1:0]  head_nxt;
  logic               push_c;
  logic               pop_c;
  logic               skip_c;

  // Handshakes: push on the input side, pop only on the current target channel
  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid[tgt_ptr] && out_ready[tgt_ptr];

`ifdef FANOUT_SKIP_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_nxt;

  // Stall counting: clears on pop or empty, fires a skip on the limit cycle
  always_comb begin
    stall_nxt = stall_cnt;
    skip_c    = 1'b0;
    if (pop_c || fifo_count == '0) begin
      stall_nxt = '0;
    end else if (out_valid != '0) begin
      if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
        stall_nxt = '0;
        skip_c    = 1'b1;
      end else begin
        stall_nxt = stall_cnt + STALL_W'(1);
      end
    end
  end

  // Stall counter and one-cycle skip indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      skip_pulse <= 1'b0;
    end else begin
      stall_cnt  <= stall_nxt;
      skip_pulse <= skip_c;
    end
  end
`else
  assign skip_c     = 1'b0;
  assign skip_pulse = 1'b0;
`endif

  // Next-state for pointers, occupancy, target and the registered outputs
  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = fifo_count;
    tgt_nxt   = tgt_ptr;
    if (pop_c) begin
      rd_nxt = rd_ptr + AW'(1);
    end
    if (push_c) begin
      wr_nxt = wr_ptr + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
    if (pop_c || skip_c) begin
      tgt_nxt = (tgt_ptr == PTR_W'(NUM_OUT - 1)) ? '0 : tgt_ptr + PTR_W'(1);
    end
    ready_nxt = (count_nxt < CNT_W'(FIFO_DEPTH));
    valid_nxt = (count_nxt != '0) ? (NUM_OUT'(1) << tgt_nxt) : '0;
    // A word written into the slot that becomes the head is forwarded directly
    head_nxt  = (push_c && wr_ptr == rd_nxt) ? in_data : mem[rd_nxt];
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Control state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      tgt_ptr    <= '0;
      in_ready   <= 1'b0;
      out_valid  <= '0;
      out_data   <= '0;
    end else begin
      rd_ptr     <= rd_nxt;
      wr_ptr     <= wr_nxt;
      fifo_count <= count_nxt;
      tgt_ptr    <= tgt_nxt;
      in_ready   <= ready_nxt;
      out_valid  <= valid_nxt;
      out_data   <= head_nxt;
    end
  end

endmodule

// File: tb/tb_fanout_dispatch_rr.sv
// Self-checking bench for fanout_dispatch_rr with a queue-based reference model.
// Define FANOUT_SKIP_EN for both bench and design to exercise the skip feature.
module tb_fanout_dispatch_rr;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_OUT     = 5;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned STALL_LIMIT = 8;
  localparam int unsigned PTR_W       = $clog2(NUM_OUT);
  localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready = '0;
  logic [DATA_W-1:0]  out_data;
  logic [PTR_W-1:0]   tgt_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               skip_pulse;

  fanout_dispatch_rr #(
    .DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .FIFO_DEPTH(FIFO_DEPTH), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tgt_ptr(tgt_ptr), .fifo_count(fifo_count), .skip_pulse(skip_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of words held, target channel, input-enable after reset
  logic [DATA_W-1:0] q[$];
  int  m_tgt   = 0;
  bit  m_in_ok = 1'b0;
  int  m_stall = 0;
  bit  m_skip  = 1'b0;
  bit  last_push = 1'b0;

  // Observed deliveries (channel, data)
  int                log_ch[$];
  logic [DATA_W-1:0] log_d[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_tgt   = 0;
    m_in_ok = 1'b0;
    m_stall = 0;
    m_skip  = 1'b0;
  endtask

  // One clock cycle: compare at negedge, advance the model, resume after posedge
  task automatic step();
    logic [NUM_OUT-1:0] ev;
    bit exp_v, do_pop, do_push;
    @(negedge clk);
    exp_v = (q.size() != 0);
    ev    = exp_v ? (NUM_OUT'(1) << m_tgt) : '0;
    check("in_ready",   64'(in_ready),   64'(m_in_ok && q.size() < FIFO_DEPTH));
    check("out_valid",  64'(out_valid),  64'(ev));
    check("fifo_count", 64'(fifo_count), 64'(q.size()));
    check("tgt_ptr",    64'(tgt_ptr),    64'(m_tgt));
    check("skip_pulse", 64'(skip_pulse), 64'(m_skip));
    if (exp_v) check("out_data", 64'(out_data), 64'(q[0]));
    for (int i = 0; i < NUM_OUT; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        log_ch.push_back(i);
        log_d.push_back(out_data);
      end
    end
    last_push = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      do_pop  = exp_v && out_ready[m_tgt];
      do_push = in_valid && m_in_ok && (q.size() < FIFO_DEPTH);
      m_skip  = 1'b0;
      if (do_pop) begin
        void'(q.pop_front());
        m_tgt   = (m_tgt + 1) % NUM_OUT;
        m_stall = 0;
      end
`ifdef FANOUT_SKIP_EN
      else if (exp_v) begin
        m_stall++;
        if (m_stall == STALL_LIMIT) begin
          m_stall = 0;
          m_tgt   = (m_tgt + 1) % NUM_OUT;
          m_skip  = 1'b1;
        end
      end else begin
        m_stall = 0;
      end
`endif
      if (do_push) q.push_back(in_data);
      last_push = do_push;
      m_in_ok   = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Offer consecutive words base, base+1, ... until n are accepted or budget runs out
  task automatic push_words(input logic [DATA_W-1:0] base, input int n, input int budget,
                            output int got, output int cycles);
    got = 0;
    cycles = 0;
    in_valid = 1'b1;
    while (cycles < budget && got < n) begin
      in_data = base + DATA_W'(got);
      step();
      cycles++;
      if (last_push) got++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int got, cyc;

    // Reset state while rst is held, then release
    #1;
    check("rst_in_ready",  64'(in_ready),   64'd0);
    check("rst_out_valid", 64'(out_valid),  64'd0);
    check("rst_count",     64'(fifo_count), 64'd0);
    check("rst_tgt",       64'(tgt_ptr),    64'd0);
    check("rst_skip",      64'(skip_pulse), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Ten back-to-back words with every child ready
    out_ready = '1;
    log_ch.delete(); log_d.delete();
    push_words(32'h0, 10, 40, got, cyc);
    check("b2b_accepted", 64'(got), 64'd10);
    for (int i = 0; i < 4; i++) step();
    check("b2b_delivered", 64'(log_ch.size()), 64'd10);
    for (int k = 0; k < 10 && k < log_ch.size(); k++) begin
      check($sformatf("b2b_ch%0d", k),   64'(log_ch[k]), 64'(k % NUM_OUT));
      check($sformatf("b2b_data%0d", k), 64'(log_d[k]),  64'(k));
    end
    check("b2b_tgt_home", 64'(tgt_ptr), 64'd0);

    // Fill with all children stalled; only four of six words are taken
    out_ready = '0;
    push_words(32'h100, 6, 8, got, cyc);
    check("full_accepted", 64'(got), 64'd4);
    check("full_count",    64'(fifo_count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head",     64'(out_data), 64'h100);

    // Release from full with the upstream still pushing: one word per cycle
    out_ready = '1;
    log_ch.delete(); log_d.delete();
    push_words(32'h104, 16, 40, got, cyc);
    check("tput_accepted", 64'(got), 64'd16);
    check("tput_cycles",   64'(cyc), 64'd17);
    for (int i = 0; i < 6; i++) step();
    check("tput_delivered", 64'(log_d.size()), 64'd20);
    for (int k = 0; k < 20 && k < log_d.size(); k++) begin
      check($sformatf("tput_data%0d", k), 64'(log_d[k]),  64'(32'h100 + k));
      check($sformatf("tput_ch%0d", k),   64'(log_ch[k]), 64'(k % NUM_OUT));
    end

    // Build count=3, tgt_ptr=2, then reset mid-transfer
    push_words(32'h200, 2, 10, got, cyc);
    for (int i = 0; i < 3; i++) step();
    out_ready = '0;
    push_words(32'h300, 3, 10, got, cyc);
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    check("pre_rst_tgt",   64'(tgt_ptr), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid),  64'd0);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_tgt",   64'(tgt_ptr),    64'd0);
    model_reset();
    step();
    rst = 1'b0;
    step();

    // Single push into empty FIFO: visible one cycle later on channel 0
    out_ready = '1;
    log_ch.delete(); log_d.delete();
    in_valid = 1'b1;
    in_data  = 32'hABCD;
    check("lat_same_cycle", 64'(out_valid), 64'd0);
    step();
    in_valid = 1'b0;
    check("lat_next_cycle", 64'(out_valid), 64'd1);
    step();
    check("post_rst_ch",   64'(log_ch.size() > 0 ? log_ch[0] : -1), 64'd0);
    check("post_rst_data", 64'(log_d.size() > 0 ? log_d[0] : 32'hX), 64'hABCD);

`ifdef FANOUT_SKIP_EN
    // Stalled channel 0 gets skipped after STALL_LIMIT cycles
    rst = 1'b1; #1; model_reset(); step(); rst = 1'b0; step();
    out_ready = ~NUM_OUT'(1);
    log_ch.delete(); log_d.delete();
    in_valid = 1'b1; in_data = 32'h5A5A;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < STALL_LIMIT; i++) step();
    check("skip_pulse_hi", 64'(skip_pulse), 64'd1);
    check("skip_tgt",      64'(tgt_ptr),    64'd1);
    check("skip_valid",    64'(out_valid),  64'd2);
    step();
    check("skip_deliv_ch", 64'(log_ch.size() > 0 ? log_ch[0] : -1), 64'd1);
    check("skip_pulse_lo", 64'(skip_pulse), 64'd0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      out_ready = (c % 150 < 40) ? NUM_OUT'($urandom()) & NUM_OUT'($urandom())
                                 : NUM_OUT'($urandom());
      step();
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
